// File: rtl/fetch_sequencer_if.sv
// Bundle of the fetch sequencer's memory, redirect and decode handshakes.
// Optional macro FETCH_MISALIGN_TRAP_EN adds the fetch_misaligned flag.
// The master modport is the sequencer side; the slave modport is the environment side.
interface fetch_sequencer_if #(
    parameter int XLEN = 32
);
    logic            fetch_en;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ack;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            fetch_misaligned;

    modport master (
        input  fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misaligned
    );

    modport slave (
        output fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, fetch_misaligned
    );
`else
    modport master (
        input  fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr
    );

    modport slave (
        output fetch_en, imem_ack, imem_rdata, redirect_valid, redirect_pc, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr
    );
`endif
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one word request at a time
// over imem req/ack, hands each instruction to decode over valid/ready, and
// squashes stale fetches when execute redirects the stream.
// Optional macro FETCH_MISALIGN_TRAP_EN: a misaligned redirect target raises
// fetch_misaligned and parks the sequencer in ERR until reset; without it the
// low two bits of every redirect target are cleared.
module fetch_sequencer #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clock,
    input  logic              reset,
    fetch_sequencer_if.master bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
`ifdef FETCH_MISALIGN_TRAP_EN
    localparam logic [2:0] S_ERR   = 3'd4;
`endif

    // Sequential word step; wraps modulo 2^XLEN.
    function automatic logic [XLEN-1:0] pc_next_word(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

    // Value loaded into the PC on a redirect.
    function automatic logic [XLEN-1:0] redirect_target(input logic [XLEN-1:0] tgt);
`ifdef FETCH_MISALIGN_TRAP_EN
        return tgt;
`else
        return tgt & ~XLEN'(3);
`endif
    endfunction

    logic [2:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            req_q, req_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic            vld_q, vld_d;
    logic [XLEN-1:0] ifpc_q, ifpc_d;
    logic [XLEN-1:0] instr_q, instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic            mis_q, mis_d;
`endif

    logic            redir;
    logic [2:0]      resume_state;
    logic            launch;

    // Redirect qualification and the state to resume in once a transaction closes.
    always_comb begin
        redir = bus.redirect_valid;
`ifdef FETCH_MISALIGN_TRAP_EN
        // ERR is terminal: further redirects are ignored until reset.
        if (state_q == S_ERR) begin
            redir = 1'b0;
        end
        mis_d = mis_q;
        if (redir && (bus.redirect_pc[1:0] != 2'b00)) begin
            mis_d = 1'b1;
        end
        if (mis_d) begin
            resume_state = S_ERR;
        end else begin
            resume_state = bus.fetch_en ? S_REQ : S_IDLE;
        end
`else
        resume_state = bus.fetch_en ? S_REQ : S_IDLE;
`endif
    end

    // Next-state, PC and decode-side register updates.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        vld_d   = vld_q;
        ifpc_d  = ifpc_q;
        instr_d = instr_q;

        // Redirect overrides any PC update made below only where no capture happens.
        if (redir) begin
            pc_d = redirect_target(bus.redirect_pc);
        end

        case (state_q)
            S_IDLE: begin
                state_d = resume_state;
            end
            S_REQ: begin
                if (bus.imem_ack) begin
                    if (redir) begin
                        // Response belongs to the old stream: drop it.
                        state_d = resume_state;
                    end else begin
                        instr_d = bus.imem_rdata;
                        ifpc_d  = pc_q;
                        vld_d   = 1'b1;
                        pc_d    = pc_next_word(pc_q);
                        state_d = S_HOLD;
                    end
                end else if (redir) begin
                    // Request cannot be withdrawn; wait out its ack and discard it.
                    state_d = S_DRAIN;
                end
            end
            S_HOLD: begin
                if (redir || bus.if_ready) begin
                    vld_d   = 1'b0;
                    state_d = resume_state;
                end
            end
            S_DRAIN: begin
                if (bus.imem_ack) begin
                    state_d = resume_state;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            S_ERR: begin
                state_d = S_ERR;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

`ifdef FETCH_MISALIGN_TRAP_EN
        // On entering ERR expose the faulting target and keep decode quiet.
        if ((state_d == S_ERR) && (state_q != S_ERR)) begin
            ifpc_d = pc_d;
            vld_d  = 1'b0;
        end
`endif
    end

    // Memory-side request register updates.
    always_comb begin
        // A new request starts whenever REQ is entered, except while one is still pending.
        launch = (state_d == S_REQ) && !((state_q == S_REQ) && !bus.imem_ack);
        req_d  = (state_d == S_REQ) || (state_d == S_DRAIN);
        addr_d = launch ? pc_d : addr_q;
    end

    // State and output registers; asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            vld_q   <= 1'b0;
            ifpc_q  <= '0;
            instr_q <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            vld_q   <= vld_d;
            ifpc_q  <= ifpc_d;
            instr_q <= instr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = addr_q;
    assign bus.if_valid  = vld_q;
    assign bus.if_pc     = ifpc_q;
    assign bus.if_instr  = instr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_misaligned = mis_q;
`endif

endmodule
